if_layer_sequencer: RTL and testbench

//  Time-step controller for one shared acc_encapsule_IF neuron, time-multiplexed over a whole layer.
//  Per step it walks neurons 0..NUM_NEURONS-1 in order. For each neuron it:
//   - reads the neuron's stored membrane voltage and loads it into the neuron;
//   - streams FAN_IN activation/weight pairs through the neuron;
//   - fires the neuron and writes the new membrane voltage back.

---
 rtl/if_ctrl_pkg.sv | 24 ++
 rtl/if_addr_gen.sv | 52 +++++
 rtl/if_layer_sequencer.sv | 173 +++++++++++++++++
 tb/tb_if_layer_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_ctrl_pkg.sv
// Shared types and constants for the IF layer sequencer.
package if_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD_REQ = 3'd1,
    LOAD   = 3'd2,
    ACC    = 3'd3,
    FIRE   = 3'd4,
    WB     = 3'd5
  } seq_state_t;

  // Read latency of the activation, weight and voltage RAMs the schedule assumes.
  localparam int RAM_RD_LAT = 1;

  // Firing threshold of the shared neuron (subtractive reset on fire).
  localparam int NRN_THRESHOLD = 127;

  // Address width for a memory of the given depth, never narrower than one bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/if_addr_gen.sv
// Address generator: activation index i, neuron index n and weight address n*FAN_IN+i.
// The weight address comes from a per-neuron base register stepped by FAN_IN,
// so no multiplier is needed.
module if_addr_gen #(
  parameter int FAN_IN = 64,
  parameter int ACT_AW = 6,
  parameter int WT_AW  = 11,
  parameter int NRN_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              rd_first,
  input  logic              rd_next,
  input  logic              nrn_next,
  output logic [ACT_AW-1:0] act_idx,
  output logic [WT_AW-1:0]  wt_idx,
  output logic [NRN_AW-1:0] nrn_idx
);

  localparam logic [WT_AW-1:0] BASE_STEP = WT_AW'(FAN_IN);

  logic [WT_AW-1:0] base;

  // Counters only move on explicit requests from the FSM; the FSM guarantees they stay in range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_idx <= '0;
      wt_idx  <= '0;
      nrn_idx <= '0;
      base    <= '0;
    end else if (clr) begin
      act_idx <= '0;
      wt_idx  <= '0;
      nrn_idx <= '0;
      base    <= '0;
    end else begin
      if (nrn_next) begin
        nrn_idx <= nrn_idx + NRN_AW'(1);
        base    <= base + BASE_STEP;
      end
      if (rd_first) begin
        act_idx <= '0;
        wt_idx  <= base;
      end else if (rd_next) begin
        act_idx <= act_idx + ACT_AW'(1);
        wt_idx  <= wt_idx + WT_AW'(1);
      end
    end
  end

endmodule

// File: rtl/if_layer_sequencer.sv
// Time-step controller that walks one shared IF neuron over every neuron of a layer:
// load membrane voltage, stream FAN_IN activation/weight pairs, fire, write back.
//
//  state  | meaning
//  IDLE   | waiting for start
//  LD_REQ | voltage RAM read for neuron n
//  LOAD   | neuron loads the voltage; first act/wt read issued
//  ACC    | FAN_IN input cycles, reads run one index ahead
//  FIRE   | neuron compares against threshold
//  WB     | new voltage written back, spike reported
module if_layer_sequencer
  import if_ctrl_pkg::*;
#(
  parameter int NUM_NEURONS = 20,
  parameter int FAN_IN      = 64,
  parameter int ACT_AW      = addr_width(FAN_IN),
  parameter int WT_AW       = addr_width(NUM_NEURONS * FAN_IN),
  parameter int NRN_AW      = addr_width(NUM_NEURONS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic              halt,
  output logic              busy,
  output logic              done,
  output logic              act_rd_en,
  output logic [ACT_AW-1:0] act_addr,
  output logic              wt_rd_en,
  output logic [WT_AW-1:0]  wt_addr,
  output logic              vol_rd_en,
  output logic [NRN_AW-1:0] vol_rd_addr,
  output logic              vol_wr_en,
  output logic [NRN_AW-1:0] vol_wr_addr,
  output logic              nrn_load_en,
  output logic              nrn_in_valid,
  output logic              nrn_out_en,
  output logic              nrn_arithm,
  input  logic              nrn_spike,
  output logic              spike_valid,
  output logic [NRN_AW-1:0] spike_idx,
  output logic [NRN_AW:0]   spike_cnt
);

  localparam logic [NRN_AW-1:0] LAST_N   = NRN_AW'(NUM_NEURONS - 1);
  localparam logic [ACT_AW-1:0] CNT_INIT = ACT_AW'(FAN_IN - 1);
  localparam logic [ACT_AW-1:0] CNT_ONE  = ACT_AW'(1);

  seq_state_t        state, state_nx;
  logic [ACT_AW-1:0] cnt, cnt_nx;
  logic [NRN_AW-1:0] nrn_idx;
  logic              clr, rd_first, rd_next, nrn_next, done_nx;

  if_addr_gen #(
    .FAN_IN (FAN_IN),
    .ACT_AW (ACT_AW),
    .WT_AW  (WT_AW),
    .NRN_AW (NRN_AW)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .rd_first (rd_first),
    .rd_next  (rd_next),
    .nrn_next (nrn_next),
    .act_idx  (act_addr),
    .wt_idx   (wt_addr),
    .nrn_idx  (nrn_idx)
  );

  assign vol_rd_addr = nrn_idx;
  assign vol_wr_addr = nrn_idx;

  // The neuron's spike output is registered and valid during WB, so it is qualified here directly.
  assign spike_valid = (state == WB) && nrn_spike;
  assign spike_idx   = spike_valid ? nrn_idx : '0;

  // Next state and counter requests; cnt is a down-counter of remaining ACC cycles.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    clr      = 1'b0;
    rd_first = 1'b0;
    rd_next  = 1'b0;
    nrn_next = 1'b0;
    done_nx  = 1'b0;
    if (halt && (state != IDLE)) begin
      state_nx = IDLE;
      done_nx  = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start && !halt) begin
            state_nx = LD_REQ;
            clr      = 1'b1;
          end
        end
        LD_REQ: begin
          state_nx = LOAD;
          rd_first = 1'b1;
        end
        LOAD: begin
          state_nx = ACC;
          cnt_nx   = CNT_INIT;
          if (FAN_IN > 1) rd_next = 1'b1;
        end
        ACC: begin
          if (cnt == '0) begin
            state_nx = FIRE;
          end else begin
            cnt_nx = cnt - CNT_ONE;
            // a read is needed next cycle only if that cycle is not the last ACC cycle
            if (cnt > CNT_ONE) rd_next = 1'b1;
          end
        end
        FIRE: state_nx = WB;
        WB: begin
          if (nrn_idx == LAST_N) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else begin
            state_nx = LD_REQ;
            nrn_next = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // State and all strobes are registered from the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      vol_rd_en    <= 1'b0;
      vol_wr_en    <= 1'b0;
      nrn_load_en  <= 1'b0;
      nrn_in_valid <= 1'b0;
      nrn_out_en   <= 1'b0;
      act_rd_en    <= 1'b0;
      wt_rd_en     <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      busy         <= (state_nx != IDLE);
      done         <= done_nx;
      vol_rd_en    <= (state_nx == LD_REQ);
      vol_wr_en    <= (state_nx == WB);
      nrn_load_en  <= (state_nx == LOAD);
      nrn_in_valid <= (state_nx == ACC);
      nrn_out_en   <= (state_nx == FIRE);
      act_rd_en    <= rd_first || rd_next;
      wt_rd_en     <= rd_first || rd_next;
    end
  end

  // Step-wide status: arithmetic mode latched at start, saturating spike count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nrn_arithm <= 1'b0;
      spike_cnt  <= '0;
    end else if (clr) begin
      nrn_arithm <= mode;
      spike_cnt  <= '0;
    end else if (spike_valid && (spike_cnt != '1)) begin
      spike_cnt <= spike_cnt + (NRN_AW + 1)'(1);
    end
  end

endmodule

// File: tb/tb_if_layer_sequencer.sv
// Bench for if_layer_sequencer: RAM and neuron models around a 2x3 instance,
// a cycle-by-cycle strobe schedule, and a 1x1 instance for the minimal case.
module tb_if_layer_sequencer;
  import if_ctrl_pkg::*;

  localparam int N1 = 2, F1 = 3;
  localparam int B_BUSY = 8, B_DONE = 7, B_VR = 6, B_LD = 5, B_IV = 4,
                 B_OE = 3, B_VW = 2, B_AR = 1, B_WR = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, start2, mode, halt;

  logic       busy, done, act_rd_en, wt_rd_en, vol_rd_en, vol_wr_en;
  logic [1:0] act_addr;
  logic [2:0] wt_addr;
  logic [0:0] vol_rd_addr, vol_wr_addr, spike_idx;
  logic       load_en, in_valid, out_en, arithm, spike_valid;
  logic [1:0] spike_cnt;
  logic       spk = 1'b0;

  logic       b_busy, b_done, b_act_rd_en, b_wt_rd_en, b_vol_rd_en, b_vol_wr_en;
  logic [0:0] b_act_addr, b_wt_addr, b_vol_rd_addr, b_vol_wr_addr, b_spike_idx;
  logic       b_load_en, b_in_valid, b_out_en, b_arithm, b_spike_valid;
  logic [1:0] b_spike_cnt;
  logic       b_spike = 1'b1;

  if_layer_sequencer #(.NUM_NEURONS(N1), .FAN_IN(F1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .halt(halt),
    .busy(busy), .done(done), .act_rd_en(act_rd_en), .act_addr(act_addr),
    .wt_rd_en(wt_rd_en), .wt_addr(wt_addr), .vol_rd_en(vol_rd_en),
    .vol_rd_addr(vol_rd_addr), .vol_wr_en(vol_wr_en), .vol_wr_addr(vol_wr_addr),
    .nrn_load_en(load_en), .nrn_in_valid(in_valid), .nrn_out_en(out_en),
    .nrn_arithm(arithm), .nrn_spike(spk), .spike_valid(spike_valid),
    .spike_idx(spike_idx), .spike_cnt(spike_cnt)
  );

  if_layer_sequencer #(.NUM_NEURONS(1), .FAN_IN(1)) dut_min (
    .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode), .halt(halt),
    .busy(b_busy), .done(b_done), .act_rd_en(b_act_rd_en), .act_addr(b_act_addr),
    .wt_rd_en(b_wt_rd_en), .wt_addr(b_wt_addr), .vol_rd_en(b_vol_rd_en),
    .vol_rd_addr(b_vol_rd_addr), .vol_wr_en(b_vol_wr_en), .vol_wr_addr(b_vol_wr_addr),
    .nrn_load_en(b_load_en), .nrn_in_valid(b_in_valid), .nrn_out_en(b_out_en),
    .nrn_arithm(b_arithm), .nrn_spike(b_spike), .spike_valid(b_spike_valid),
    .spike_idx(b_spike_idx), .spike_cnt(b_spike_cnt)
  );

  logic [8:0]  ctl1, ctl2;
  logic [20:0] all1, all2;
  assign ctl1 = {busy, done, vol_rd_en, load_en, in_valid, out_en, vol_wr_en, act_rd_en, wt_rd_en};
  assign ctl2 = {b_busy, b_done, b_vol_rd_en, b_load_en, b_in_valid, b_out_en, b_vol_wr_en,
                 b_act_rd_en, b_wt_rd_en};
  assign all1 = {busy, done, act_rd_en, act_addr, wt_rd_en, wt_addr, vol_rd_en, vol_rd_addr,
                 vol_wr_en, vol_wr_addr, load_en, in_valid, out_en, arithm, spike_valid,
                 spike_idx, spike_cnt};
  assign all2 = {b_busy, b_done, b_act_rd_en, b_act_addr, b_wt_rd_en, 2'b00, b_wt_addr,
                 b_vol_rd_en, b_vol_rd_addr, b_vol_wr_en, b_vol_wr_addr, b_load_en, b_in_valid,
                 b_out_en, b_arithm, b_spike_valid, b_spike_idx, b_spike_cnt};

  // RAM models with one-cycle read latency, plus the neuron model.
  int   act_init [4];
  int   vol_init [2];
  int   act_mem  [4];
  int   wt_mem   [8];
  int   vol_mem  [2];
  int   act_q, wt_q, vol_q, mem, out_vol, vol_wr_seen;
  logic ram_init;

  always @(posedge clk) begin
    if (ram_init) begin
      act_mem     <= act_init;
      vol_mem     <= vol_init;
      wt_mem      <= '{1, 2, 3, -1, 0, 2, 0, 0};
      vol_wr_seen <= 0;
    end else begin
      if (act_rd_en) act_q <= act_mem[act_addr];
      if (wt_rd_en)  wt_q  <= wt_mem[wt_addr];
      if (vol_rd_en) vol_q <= vol_mem[vol_rd_addr];
      if (vol_wr_en) begin
        vol_mem[vol_wr_addr] <= out_vol;
        vol_wr_seen          <= vol_wr_seen + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (load_en)       mem <= vol_q;
    else if (in_valid) mem <= mem + (arithm ? act_q : act_q * wt_q);
    if (out_en) begin
      if (mem >= NRN_THRESHOLD) begin
        out_vol <= mem - NRN_THRESHOLD;
        spk     <= 1'b1;
      end else begin
        out_vol <= mem;
        spk     <= 1'b0;
      end
    end
  end

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  // Expected strobes t cycles after the first LD_REQ; also the neuron n and read index i.
  function automatic logic [8:0] sched(input int t, input int nn, input int fi,
                                       output int n, output int i);
    int per, p;
    logic [8:0] e;
    per = fi + 4;
    n = t / per;
    p = t % per;
    i = 0;
    e = '0;
    if (t >= nn * per) begin
      n = 0;
      e[B_DONE] = 1'b1;
      return e;
    end
    e[B_BUSY] = 1'b1;
    if (p == 0) e[B_VR] = 1'b1;
    else if (p == 1) begin
      e[B_LD] = 1'b1; e[B_AR] = 1'b1; e[B_WR] = 1'b1;
    end else if (p < fi + 2) begin
      e[B_IV] = 1'b1;
      i = p - 1;
      if (p - 1 < fi) begin e[B_AR] = 1'b1; e[B_WR] = 1'b1; end
    end else if (p == fi + 2) e[B_OE] = 1'b1;
    else e[B_VW] = 1'b1;
    return e;
  endfunction

  task automatic load_ram(input int a0, input int a1, input int a2, input int v0, input int v1);
    act_init = '{a0, a1, a2, 0};
    vol_init = '{v0, v1};
    @(negedge clk) ram_init = 1'b1;
    @(negedge clk) ram_init = 1'b0;
  endtask

  // One step on the 2x3 instance, optionally with a stray start, a halt or a reset at cycle t.
  task automatic run_step1(input logic md, input logic [1:0] sp, input int ecnt,
                           input int extra_start, input int halt_at, input int rst_at);
    int n, i, last;
    logic [8:0] e;
    logic sv;
    last = N1 * (F1 + 4);
    @(negedge clk); start = 1'b1; mode = md;
    @(negedge clk); start = 1'b0;
    for (int t = 0; t <= last; t++) begin
      e = sched(t, N1, F1, n, i);
      chk($sformatf("ctl t=%0d", t), 32'(ctl1), 32'(e));
      chk($sformatf("arithm t=%0d", t), 32'(arithm), 32'(md));
      if (e[B_VR]) chk($sformatf("vol_rd_addr t=%0d", t), 32'(vol_rd_addr), n);
      if (e[B_AR]) begin
        chk($sformatf("act_addr t=%0d", t), 32'(act_addr), i);
        chk($sformatf("wt_addr t=%0d", t), 32'(wt_addr), n * F1 + i);
      end
      if (e[B_VW]) chk($sformatf("vol_wr_addr t=%0d", t), 32'(vol_wr_addr), n);
      sv = e[B_VW] ? sp[n] : 1'b0;
      chk($sformatf("spike_valid t=%0d", t), 32'(spike_valid), 32'(sv));
      if (sv) chk($sformatf("spike_idx t=%0d", t), 32'(spike_idx), n);
      if (t == last) chk("spike_cnt", 32'(spike_cnt), ecnt);
      start = (t == extra_start);
      if (t == halt_at) begin
        halt = 1'b1;
        @(negedge clk); halt = 1'b0;
        chk("halt ctl", 32'(ctl1), 32'h080);
        return;
      end
      if (t == rst_at) begin
        rst_n = 1'b0;
        #1 chk("async reset outputs", 32'(all1), 0);
        @(negedge clk); rst_n = 1'b1;
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("post-done ctl", 32'(ctl1), 0);
  endtask

  typedef struct packed {
    logic       md;
    int         a0, a1, a2, v0, v1, e0, e1;
    logic [1:0] sp;
    int         cnt;
  } vec_t;
  vec_t vecs [5];

  initial begin
    int rd_cnt, n, i;
    logic [8:0] e;
    // mode, acts, initial volts, expected volts, spikes {n1,n0}, spike count
    vecs[0] = '{1'b1, 50, 50, 50,    0,   0, 23,  23, 2'b11, 2};
    vecs[1] = '{1'b1, 60, 60, 60, -100,   0, 80,  53, 2'b10, 1};
    vecs[2] = '{1'b0, 10, 20, 30,    0,   0, 13,  50, 2'b01, 1};
    vecs[3] = '{1'b1,  0,  0,  0,  127, 126,  0, 126, 2'b01, 1};
    vecs[4] = '{1'b0,  5,  5,  5,  -50, 127, -20,  5, 2'b10, 1};

    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; mode = 1'b0; halt = 1'b0; ram_init = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset outputs", 32'(all1), 0);
    chk("reset outputs min", 32'(all2), 0);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      load_ram(vecs[v].a0, vecs[v].a1, vecs[v].a2, vecs[v].v0, vecs[v].v1);
      run_step1(vecs[v].md, vecs[v].sp, vecs[v].cnt, -1, -1, -1);
      @(negedge clk);
      chk($sformatf("vec%0d vol[0]", v), vol_mem[0], vecs[v].e0);
      chk($sformatf("vec%0d vol[1]", v), vol_mem[1], vecs[v].e1);
    end

    // stray start in the middle of a step is dropped
    load_ram(60, 60, 60, -100, 0);
    run_step1(1'b1, 2'b10, 1, 5, -1, -1);
    chk("stray start no restart", 32'(ctl1), 0);
    chk("stray start vol[1]", vol_mem[1], 53);

    // halt during neuron 0 accumulation
    load_ram(50, 50, 50, 77, 77);
    run_step1(1'b1, 2'b00, 0, -1, 3, -1);
    @(negedge clk);
    chk("after halt ctl", 32'(ctl1), 0);
    chk("halt writes", vol_wr_seen, 0);
    chk("halt vol[0]", vol_mem[0], 77);

    // halt and start together in IDLE
    @(negedge clk); start = 1'b1; halt = 1'b1;
    @(negedge clk); start = 1'b0; halt = 1'b0;
    chk("halt+start ctl", 32'(ctl1), 0);
    @(negedge clk);
    chk("halt+start ctl later", 32'(ctl1), 0);

    // reset in FIRE of neuron 0, then a clean step
    load_ram(50, 50, 50, 77, 77);
    run_step1(1'b1, 2'b00, 0, -1, -1, 5);
    chk("reset writes", vol_wr_seen, 0);
    chk("reset vol[0]", vol_mem[0], 77);
    load_ram(vecs[3].a0, vecs[3].a1, vecs[3].a2, vecs[3].v0, vecs[3].v1);
    run_step1(vecs[3].md, vecs[3].sp, vecs[3].cnt, -1, -1, -1);
    @(negedge clk);
    chk("post-reset vol[0]", vol_mem[0], vecs[3].e0);
    chk("post-reset vol[1]", vol_mem[1], vecs[3].e1);

    // single neuron, single input
    rd_cnt = 0;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    for (int t = 0; t <= 5; t++) begin
      e = sched(t, 1, 1, n, i);
      chk($sformatf("min ctl t=%0d", t), 32'(ctl2), 32'(e));
      if (e[B_AR]) begin
        chk($sformatf("min act_addr t=%0d", t), 32'(b_act_addr), 0);
        chk($sformatf("min wt_addr t=%0d", t), 32'(b_wt_addr), 0);
      end
      if (b_act_rd_en) rd_cnt++;
      if (t == 5) chk("min spike_cnt", 32'(b_spike_cnt), 1);
      if (t < 5) @(negedge clk);
    end
    chk("min act reads", rd_cnt, 1);
    @(negedge clk);
    chk("min post-done ctl", 32'(ctl2), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
